// File: rtl/cpu_mem_pkg.sv
// Shared types for the fetch/data memory port arbiter.
//   arb_state_t : arbiter sequencing state (idle, command issued, waiting for response)
//   arb_owner_t : which requester owns the outstanding transaction
//   arb_pick    : grant decision for one arbitration cycle
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

    // Data wins unless fetch is also pending and data has already used up its streak.
    // Only meaningful when at least one of the pending inputs is set.
    function automatic arb_owner_t arb_pick(input logic if_pend,
                                            input logic d_pend,
                                            input logic at_limit);
        if (d_pend && !(if_pend && at_limit)) begin
            return OWN_D;
        end
        return OWN_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch requester (read-only) and the
// data requester (read/write). One transaction outstanding at a time; data has
// priority, bounded by a streak limit so fetch cannot starve.
//
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request (held until if_ready)
//   if_rdata/if_ready/if_stall      fetch response data, completion pulse, stall
//   d_req/d_we/d_wstrb/d_addr/d_wdata  data request (held until d_ready)
//   d_rdata/d_ready/d_stall         data response data, completion pulse, stall
//   m_req/m_we/m_wstrb/m_addr/m_wdata  registered memory command, m_req held until m_gnt
//   m_gnt/m_rvalid/m_rdata          memory accept, response valid, read data
//   busy                            a transaction is in flight
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ready,
    output logic                  if_stall,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ready,
    output logic                  d_stall,

    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,

    output logic                  busy
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_t          state;
    arb_owner_t          owner;
    logic [STREAK_W-1:0] streak;

    logic       if_pend;
    logic       d_pend;
    logic       any_pend;
    logic       at_limit;
    arb_owner_t pick;

    // A requester whose ready is pulsing still holds req for the transaction just
    // finished; it must not be taken as a fresh request.
    assign if_pend  = if_req & ~if_ready;
    assign d_pend   = d_req & ~d_ready;
    assign any_pend = if_pend | d_pend;
    assign at_limit = (streak == STREAK_MAX);
    assign pick     = arb_pick(if_pend, d_pend, at_limit);

    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;
    assign busy     = (state != ARB_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            owner    <= OWN_IF;
            streak   <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_wstrb  <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            unique case (state)
                ARB_IDLE: begin
                    if (any_pend) begin
                        owner <= pick;
                        m_req <= 1'b1;
                        state <= ARB_ISSUE;
                        if (pick == OWN_D) begin
                            m_we    <= d_we;
                            m_wstrb <= d_wstrb;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            // Count only grants that made a waiting fetch wait longer.
                            if (!if_pend) begin
                                streak <= '0;
                            end else if (!at_limit) begin
                                streak <= streak + STREAK_W'(1);
                            end
                        end else begin
                            m_we    <= 1'b0;
                            m_wstrb <= '0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                            streak  <= '0;
                        end
                    end
                end

                ARB_ISSUE: begin
                    if (m_gnt) begin
                        m_req <= 1'b0;
                        state <= ARB_WAIT;
                    end
                end

                ARB_WAIT: begin
                    if (m_rvalid) begin
                        state <= ARB_IDLE;
                        if (owner == OWN_D) begin
                            d_ready <= 1'b1;
                            // Write responses carry no data; keep the last read value.
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= m_rdata;
                        end
                    end
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int          LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [SW-1:0] d_wstrb;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          d_stall;
    logic          m_req;
    logic          m_we;
    logic [SW-1:0] m_wstrb;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_gnt;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one outstanding transaction, described by who owns it,
    // whether memory has accepted it, and the command captured at grant time.
    bit            mdl_busy;
    bit            mdl_granted;
    bit            mdl_own_d;
    bit            mdl_we;
    logic [SW-1:0] mdl_wstrb;
    logic [AW-1:0] mdl_addr;
    logic [DW-1:0] mdl_wdata;
    int            mdl_streak;
    bit            exp_if_ready;
    bit            exp_d_ready;
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_d_rdata;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_rdata(if_rdata),
        .if_ready(if_ready),
        .if_stall(if_stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_wstrb (d_wstrb),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .d_stall (d_stall),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_wstrb (m_wstrb),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_gnt   (m_gnt),
        .m_rvalid(m_rvalid),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mdl_busy     = 0;
        mdl_granted  = 0;
        mdl_own_d    = 0;
        mdl_we       = 0;
        mdl_wstrb    = '0;
        mdl_addr     = '0;
        mdl_wdata    = '0;
        mdl_streak   = 0;
        exp_if_ready = 0;
        exp_d_ready  = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
    endtask

    // Advance one clock; the model sees the inputs as they stood before the edge.
    task automatic tick();
        bit            ifr = if_req;
        bit            dr  = d_req;
        bit            we  = d_we;
        bit            gnt = m_gnt;
        bit            rv  = m_rvalid;
        logic [SW-1:0] st  = d_wstrb;
        logic [AW-1:0] ia  = if_addr;
        logic [AW-1:0] da  = d_addr;
        logic [DW-1:0] wd  = d_wdata;
        logic [DW-1:0] rd  = m_rdata;
        bit            ifp;
        bit            dp;
        bit            nir = 0;
        bit            ndr = 0;
        @(posedge clk);
        ifp = ifr && !exp_if_ready;
        dp  = dr && !exp_d_ready;
        if (!mdl_busy) begin
            if (dp && !(ifp && mdl_streak == LIM)) begin
                mdl_busy = 1; mdl_granted = 0; mdl_own_d = 1;
                mdl_we = we; mdl_wstrb = st; mdl_addr = da; mdl_wdata = wd;
                mdl_streak = ifp ? ((mdl_streak < LIM) ? mdl_streak + 1 : LIM) : 0;
            end else if (ifp) begin
                mdl_busy = 1; mdl_granted = 0; mdl_own_d = 0;
                mdl_we = 0; mdl_wstrb = '0; mdl_addr = ia; mdl_wdata = '0;
                mdl_streak = 0;
            end
        end else if (!mdl_granted) begin
            if (gnt) mdl_granted = 1;
        end else if (rv) begin
            mdl_busy = 0;
            if (mdl_own_d) begin
                ndr = 1;
                if (!mdl_we) exp_d_rdata = rd;
            end else begin
                nir = 1;
                exp_if_rdata = rd;
            end
        end
        exp_if_ready = nir;
        exp_d_ready  = ndr;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_wstrb = '0; d_addr = '0;
        d_wdata = '0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
        model_reset();
        #12;
        n_cmp++;
        if ({m_req, m_we, m_wstrb, m_addr, m_wdata, if_rdata, d_rdata, if_ready, d_ready}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got m_req=%b m_addr=%h if_rdata=%h d_rdata=%h want 0",
                     m_req, m_addr, if_rdata, d_rdata);
        end
        n_cmp++;
        if ({busy, if_stall, d_stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 000", {busy, if_stall, d_stall});
        end
        reset = 1'b1;
        // Stale response with nothing outstanding must be dropped.
        m_rvalid = 1; m_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({if_ready, d_ready, busy, m_req} !== 4'b0000) begin
                n_fail++;
                $display("FAIL stale_rvalid: got rdy/busy/req=%b want 0000",
                         {if_ready, d_ready, busy, m_req});
            end
        end
        m_rvalid = 0;
    endtask

    task automatic test_lone_fetch();
        if_req = 1; if_addr = 32'h40; m_gnt = 1;
        tick();
        n_cmp++;
        if ({m_req, busy, m_we} !== 3'b110 || m_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL fetch_c1: got req=%b busy=%b we=%b addr=%h want 1 1 0 00000040",
                     m_req, busy, m_we, m_addr);
        end
        tick();
        n_cmp++;
        if ({m_req, busy, if_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL fetch_c2: got req/busy/rdy=%b want 010", {m_req, busy, if_ready});
        end
        m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if ({if_ready, d_ready, busy, if_stall} !== 4'b1000 || if_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL fetch_c3: got rdy/drdy/busy/stall=%b rdata=%h want 1000 deadbeef",
                     {if_ready, d_ready, busy, if_stall}, if_rdata);
        end
        if_req = 0; m_rvalid = 0;
        tick();
        n_cmp++;
        if ({if_ready, m_req, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL fetch_c4: got rdy/req/busy=%b want 000", {if_ready, m_req, busy});
        end
    endtask

    task automatic test_priority();
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h200;
        m_gnt = 1; m_rvalid = 1; m_rdata = 32'hA5A5_0001;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                n_cmp++;
                if (m_req !== 1'b1 || m_addr !== 32'h200 || if_stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL prio_d_first: got req=%b addr=%h stall=%b want 1 00000200 1",
                             m_req, m_addr, if_stall);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({d_ready, if_ready, if_stall, d_stall} !== 4'b1010 ||
                    d_rdata !== 32'hA5A5_0001) begin
                    n_fail++;
                    $display("FAIL prio_d_ready: got %b rdata=%h want 1010 a5a50001",
                             {d_ready, if_ready, if_stall, d_stall}, d_rdata);
                end
                d_req = 0;
            end
            if (c == 4) begin
                n_cmp++;
                if (m_req !== 1'b1 || m_addr !== 32'h80 || d_ready !== 1'b0 ||
                    if_stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL prio_if_next: got req=%b addr=%h drdy=%b want 1 00000080 0",
                             m_req, m_addr, d_ready);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (if_ready !== 1'b1 || if_rdata !== 32'hA5A5_0001) begin
                    n_fail++;
                    $display("FAIL prio_if_ready: got rdy=%b rdata=%h want 1 a5a50001",
                             if_ready, if_rdata);
                end
                if_req = 0; m_gnt = 0; m_rvalid = 0;
            end
        end
        tick();
    endtask

    task automatic test_write_stall();
        d_req = 1; d_we = 1; d_wstrb = 4'b0011; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        m_gnt = 0; m_rvalid = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_cmp++;
            if ({m_req, m_we, m_wstrb} !== 6'b110011 || m_addr !== 32'h100 ||
                m_wdata !== 32'h1234_5678) begin
                n_fail++;
                $display("FAIL write_hold c%0d: got req=%b we=%b strb=%b addr=%h wdata=%h",
                         c, m_req, m_we, m_wstrb, m_addr, m_wdata);
            end
        end
        m_gnt = 1;
        tick();
        n_cmp++;
        if (m_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_gnt: got req=%b busy=%b want 0 1", m_req, busy);
        end
        m_gnt = 0; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
        tick();
        n_cmp++;
        if (d_ready !== 1'b1 || d_rdata !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL write_resp: got rdy=%b rdata=%h want 1 a5a50001", d_ready, d_rdata);
        end
        d_req = 0; d_we = 0; m_rvalid = 0;
        tick();
    endtask

    task automatic test_held_both();
        if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
        m_gnt = 1; m_rvalid = 1;
        for (int i = 0; i < 40; i++) begin
            m_rdata = $urandom;
            tick();
            if (i == 0) begin
                n_cmp++;
                if (m_addr !== 32'h2000) begin
                    n_fail++;
                    $display("FAIL held_first: got addr=%h want 00002000", m_addr);
                end
            end
            n_cmp++;
            if (m_req !== (mdl_busy && !mdl_granted) || m_addr !== mdl_addr ||
                if_ready !== exp_if_ready || d_ready !== exp_d_ready) begin
                n_fail++;
                $display("FAIL held_order i%0d: got req=%b addr=%h rdy=%b%b want %b %h %b%b",
                         i, m_req, m_addr, if_ready, d_ready, mdl_busy && !mdl_granted,
                         mdl_addr, exp_if_ready, exp_d_ready);
            end
        end
        if_req = 0; d_req = 0;
        for (int i = 0; i < 4; i++) tick();
        m_gnt = 0; m_rvalid = 0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_addr_change();
        int pulses = 0;
        d_req = 1; d_we = 0; d_addr = 32'h300; m_gnt = 0; m_rvalid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            d_addr = $urandom;
            d_wdata = $urandom;
            tick();
            n_cmp++;
            if (m_req !== 1'b1 || m_addr !== 32'h300) begin
                n_fail++;
                $display("FAIL addr_latched i%0d: got req=%b addr=%h want 1 00000300",
                         i, m_req, m_addr);
            end
        end
        m_gnt = 1;
        tick();
        m_gnt = 0; m_rvalid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d_ready) pulses++;
            d_req = 0; m_rvalid = 0;
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL addr_single_ready: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        if_req = 1; if_addr = 32'h44; m_gnt = 1; m_rvalid = 0;
        tick();
        tick();
        m_gnt = 0;
        #2;
        reset = 1'b0; if_req = 0;
        #1;
        model_reset();
        n_cmp++;
        if ({m_req, m_we, m_wstrb, m_addr, m_wdata, if_rdata, d_rdata, if_ready, d_ready,
             busy, if_stall, d_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b m_addr=%h if_rdata=%h d_rdata=%h want 0",
                     busy, m_addr, if_rdata, d_rdata);
        end
        #3;
        reset = 1'b1;
        m_rvalid = 1; m_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({if_ready, d_ready, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_abandon i%0d: got rdy/busy=%b want 000",
                         i, {if_ready, d_ready, busy});
            end
        end
        m_rvalid = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            tick();
            n_cmp++;
            if (m_req !== (mdl_busy && !mdl_granted) || busy !== mdl_busy) begin
                n_fail++;
                $display("FAIL rnd_req i%0d: got req=%b busy=%b want %b %b",
                         i, m_req, busy, mdl_busy && !mdl_granted, mdl_busy);
            end
            n_cmp++;
            if (m_we !== mdl_we || m_wstrb !== mdl_wstrb || m_addr !== mdl_addr ||
                m_wdata !== mdl_wdata) begin
                n_fail++;
                $display("FAIL rnd_cmd i%0d: got %b %b %h %h want %b %b %h %h", i, m_we,
                         m_wstrb, m_addr, m_wdata, mdl_we, mdl_wstrb, mdl_addr, mdl_wdata);
            end
            n_cmp++;
            if (if_ready !== exp_if_ready || d_ready !== exp_d_ready) begin
                n_fail++;
                $display("FAIL rnd_ready i%0d: got %b%b want %b%b",
                         i, if_ready, d_ready, exp_if_ready, exp_d_ready);
            end
            n_cmp++;
            if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
                n_fail++;
                $display("FAIL rnd_rdata i%0d: got %h %h want %h %h",
                         i, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
            end
            n_cmp++;
            if (if_stall !== (if_req && !exp_if_ready) || d_stall !== (d_req && !exp_d_ready))
            begin
                n_fail++;
                $display("FAIL rnd_stall i%0d: got %b%b want %b%b", i, if_stall, d_stall,
                         if_req && !exp_if_ready, d_req && !exp_d_ready);
            end
            // Requesters hold req until ready, may issue again at once, and may
            // walk away after their command has been captured.
            if (if_req && exp_if_ready) if_req = ($urandom_range(0, 1) == 1);
            else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
            else if (mdl_busy && !mdl_own_d && $urandom_range(0, 7) == 0) if_req = 0;
            if (d_req && exp_d_ready) d_req = ($urandom_range(0, 1) == 1);
            else if (!d_req) d_req = ($urandom_range(0, 1) == 0);
            else if (mdl_busy && mdl_own_d && $urandom_range(0, 7) == 0) d_req = 0;
            if_addr  = $urandom;
            d_addr   = $urandom;
            d_wdata  = $urandom;
            d_wstrb  = SW'($urandom);
            d_we     = ($urandom_range(0, 1) == 1);
            m_gnt    = ($urandom_range(0, 1) == 1);
            m_rvalid = ($urandom_range(0, 1) == 1);
            m_rdata  = $urandom;
        end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_priority();
        test_write_stall();
        test_held_both();
        test_addr_change();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
